decade_counter: RTL and testbench
=================================

DECADE_COUNTER -- requirements
Module: decade_counter

Interface
- REQ-001: Parameter MODULUS, default 10, count modulus; the only supported value is 10, and the terminal value is MODULUS-1 = 9.
- REQ-002: Parameter WIDTH, default 4, width of cnt; the only supported value is 4.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  reset; synchronous, active-high.
- REQ-005: enable  input  1  count enable; active-high.
- REQ-006: cnt  output  WIDTH  current count value (0..9), registered.
- REQ-007: tc  output  1  terminal count; combinational.
- REQ-008: seg  output  7  seven-segment pattern {g,f,e,d,c,b,a}, active-high; present only with DECADE_COUNTER_SEG_EN.
- REQ-009: Port declaration order SHALL be enable, clk, reset, cnt, tc, then seg when present, to support positional instantiation with the first four ports.

Function
- REQ-010: On a rising clk edge with reset=1, cnt SHALL load 0 regardless of enable.
- REQ-011: On a rising clk edge with reset=0, enable=1 and cnt<9, cnt SHALL increment by 1.
- REQ-012: On a rising clk edge with reset=0, enable=1 and cnt=9, cnt SHALL wrap to 0.
- REQ-013: On a rising clk edge with reset=0 and enable=0, cnt SHALL hold its value.
- REQ-014: If cnt is ever 10..15, the next rising clk edge SHALL load 0 regardless of enable, for illegal-state recovery.
- REQ-015: tc SHALL equal (cnt==9) AND enable AND NOT reset, combinationally, so it asserts in the cycle before the wrap.
- REQ-016: Latency from enable sampled high to cnt change SHALL be one clk cycle; tc has zero-cycle latency.
- REQ-017: reset SHALL have priority over enable and over illegal-state recovery.

Reset
- REQ-018: Reset SHALL be synchronous and active-high; there is no asynchronous reset path.
- REQ-019: Values after a reset edge: cnt=0, tc=0, seg=pattern for 0 (0111111).
- REQ-020: Before the first reset edge, cnt is undefined; the bench SHALL NOT check it.
- REQ-021: Reset asserted mid-count SHALL take effect at the next rising edge; counting resumes from 0 on the first enabled edge after reset deasserts.

Configuration
- REQ-022: Macro DECADE_COUNTER_SEG_EN, when defined, SHALL add output seg, a combinational decode of cnt.
  - Digit patterns, {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Illegal cnt values decode to 0000000.
- REQ-023: Without DECADE_COUNTER_SEG_EN, seg SHALL be absent and no decode logic synthesized; all other behaviour is identical.

Structure
- REQ-024: Package decade_counter_pkg SHALL hold:
  - the MODULUS and terminal-value constants;
  - a 4-bit count typedef;
  - the seven-segment pattern constants for digits 0..9 and blank.
- REQ-025: The seven-segment decode SHALL be one sub-module, bcd_to_seg (4-bit in, 7-bit out, purely combinational), instantiated only under DECADE_COUNTER_SEG_EN.
- REQ-026: The count register, next-state logic and tc SHALL reside in decade_counter itself.

Verification
- REQ-027: reset=1 and enable=1 for 2 edges -> cnt=0 and tc=0 after each edge.
- REQ-028: reset=0, enable=1 for 12 edges from 0 -> cnt sequence 1,2,...,9,0,1,2; tc=1 only while cnt=9.
- REQ-029: enable=0 for 5 edges with cnt=4 -> cnt stays 4 and tc=0 throughout.
- REQ-030: Counting, reset=1 for one edge while cnt=5 -> cnt=0 at that edge; with enable=1, next edge gives cnt=1.
- REQ-031: enable=0 while cnt=9 -> tc=0 and cnt holds 9; setting enable=1 -> tc=1 immediately and cnt=0 at the next edge.
- REQ-032: With DECADE_COUNTER_SEG_EN, step cnt through 0..9 -> seg matches the REQ-022 table at each value, e.g. cnt=8 gives 1111111.

Source files
------------

// File: rtl/decade_counter_pkg.sv
// Shared constants and types for the decade counter and its seven-segment decoder.
package decade_counter_pkg;

    localparam int DC_MODULUS  = 10;
    localparam int DC_WIDTH    = 4;
    localparam int DC_TERMINAL = DC_MODULUS - 1;

    typedef logic [3:0] count_t;

    // Segment patterns are {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to seven-segment decoder; non-decimal inputs blank the display.
module bcd_to_seg
    import decade_counter_pkg::*;
(
    input  count_t     i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/decade_counter.sv
// Mod-10 counter with synchronous reset, enable and combinational terminal count.
// Defining DECADE_COUNTER_SEG_EN adds the seven-segment output seg.
module decade_counter
    import decade_counter_pkg::*;
#(
    parameter int MODULUS = DC_MODULUS,
    parameter int WIDTH   = DC_WIDTH
)
(
    input  logic             enable,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
`ifdef DECADE_COUNTER_SEG_EN
    ,
    output logic [6:0]       seg
`endif
);

    localparam logic [WIDTH-1:0] LP_TERMINAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cntNext;

    // Out-of-range values (only reachable by upset) return to zero regardless of enable.
    always_comb begin
        w_cntNext = r_cnt;
        if (r_cnt > LP_TERMINAL) begin
            w_cntNext = '0;
        end else if (enable) begin
            if (r_cnt == LP_TERMINAL) begin
                w_cntNext = '0;
            end else begin
                w_cntNext = r_cnt + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cntNext;
        end
    end

    assign cnt = r_cnt;
    assign tc  = (r_cnt == LP_TERMINAL) && enable && !reset;

`ifdef DECADE_COUNTER_SEG_EN
    bcd_to_seg u_bcdToSeg (
        .i_bcd (count_t'(r_cnt)),
        .o_seg (seg)
    );
`endif

endmodule

// File: tb/tb_decade_counter.sv
// Self-checking bench for decade_counter against a modulo-10 reference model.
// Seg checks are active when DECADE_COUNTER_SEG_EN is defined.
module tb_decade_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] cnt;
    logic       tc;
`ifdef DECADE_COUNTER_SEG_EN
    logic [6:0] seg;
`endif

    int errors = 0;
    int checks = 0;
    int modelCnt = 0;
    bit modelValid = 0;

    // Reference digit patterns {g..a}, indexed by decimal digit.
    logic [6:0] segTable [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                  7'b1111111, 7'b1101111};

    decade_counter dut (
        .enable (enable),
        .clk    (clk),
        .reset  (reset),
        .cnt    (cnt),
        .tc     (tc)
`ifdef DECADE_COUNTER_SEG_EN
        ,
        .seg    (seg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic expectedTc();
        return (modelCnt == 9) && enable && !reset;
    endfunction

    task automatic checkTc(input string tag);
        logic expTc;
        expTc = expectedTc();
        checks++;
        assert (tc === expTc) else begin
            errors++;
            $error("[TB] FAIL %s tc: got %b expected %b (model cnt %0d)", tag, tc, expTc, modelCnt);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] expCnt;
        expCnt = 4'(modelCnt);
        checks++;
        assert (cnt === expCnt) else begin
            errors++;
            $error("[TB] FAIL %s cnt: got %0d expected %0d", tag, cnt, expCnt);
        end
        checkTc(tag);
`ifdef DECADE_COUNTER_SEG_EN
        checks++;
        assert (seg === segTable[modelCnt]) else begin
            errors++;
            $error("[TB] FAIL %s seg: got %b expected %b", tag, seg, segTable[modelCnt]);
        end
`endif
    endtask

    // One clock step: drive on the falling edge, check tc before and state after the rising edge.
    task automatic applyStimulus(input logic en, input logic rst, input string tag);
        @(negedge clk);
        enable = en;
        reset  = rst;
        #1;
        if (modelValid) checkTc({tag, "/pre"});
        @(posedge clk);
        #1;
        if (rst) begin
            modelCnt   = 0;
            modelValid = 1;
        end else if (en && modelValid) begin
            modelCnt = (modelCnt + 1) % 10;
        end
        if (modelValid) checkOutput({tag, "/post"});
    endtask

    initial begin
        enable = 1'b0;
        reset  = 1'b0;

        applyStimulus(1'b1, 1'b1, "resetA");
        applyStimulus(1'b1, 1'b1, "resetB");

        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, "count12");
        applyStimulus(1'b1, 1'b0, "toFour");
        applyStimulus(1'b1, 1'b0, "toFour");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, "hold4");

        applyStimulus(1'b1, 1'b0, "toFive");
        applyStimulus(1'b1, 1'b1, "midReset");
        applyStimulus(1'b1, 1'b0, "afterReset");

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, "toNine");
        applyStimulus(1'b0, 1'b0, "hold9");
        applyStimulus(1'b0, 1'b0, "hold9");
        applyStimulus(1'b1, 1'b0, "wrap9");

        applyStimulus(1'b0, 1'b1, "segReset");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, "segWalk");

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 16) == 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
